// File: rtl/conv_stream_layer.sv
// Streaming 3x3 convolution layer: raster pixels in, NUM_OC channel results per window out.
// Line buffer and window feed a product stage and an adder-tree stage, all under one valid/ready advance.
module conv_stream_layer #(
   parameter  int DATA_BITS = 16,
   parameter  int WIDTH     = 28,
   parameter  int HEIGHT    = 28,
   parameter  int STRIDE    = 1,
   parameter  int NUM_OC    = 4,
   parameter  int RELU      = 1,
   localparam int OUT_BITS  = 2*DATA_BITS+4,
   localparam int OW        = (WIDTH-3)/STRIDE+1,
   localparam int OH        = (HEIGHT-3)/STRIDE+1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [DATA_BITS-1:0]   in_data,
   input  logic [NUM_OC*9*DATA_BITS-1:0] weights,
   input  logic [NUM_OC*DATA_BITS-1:0]   bias,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_OC*OUT_BITS-1:0]    out_data,
   output logic [$clog2(OH):0]           out_row,
   output logic [$clog2(OW):0]           out_col,
   output logic                          frame_done
);

   localparam int CCW = $clog2(WIDTH);
   localparam int RCW = $clog2(HEIGHT);
   localparam int ORW = $clog2(OH)+1;
   localparam int OCW = $clog2(OW)+1;
   localparam int PW  = 2*DATA_BITS;
   localparam int SH  = STRIDE-1;
   localparam logic [CCW-1:0] COL_LAST  = CCW'(WIDTH-1);
   localparam logic [RCW-1:0] ROW_LAST  = RCW'(HEIGHT-1);
   localparam logic [ORW-1:0] OROW_LAST = ORW'(OH-1);
   localparam logic [OCW-1:0] OCOL_LAST = OCW'(OW-1);

   if ((STRIDE != 1) && (STRIDE != 2)) begin : g_bad_stride
      $error("conv_stream_layer: STRIDE must be 1 or 2");
   end

   function automatic logic signed [PW-1:0] mul_ext(input logic signed [DATA_BITS-1:0] a,
                                                    input logic signed [DATA_BITS-1:0] b);
      logic signed [PW-1:0] ax;
      logic signed [PW-1:0] bx;
      ax = {{DATA_BITS{a[DATA_BITS-1]}}, a};
      bx = {{DATA_BITS{b[DATA_BITS-1]}}, b};
      return ax * bx;
   endfunction

   function automatic logic signed [OUT_BITS-1:0] sext_prod(input logic signed [PW-1:0] p);
      return {{(OUT_BITS-PW){p[PW-1]}}, p};
   endfunction

   function automatic logic signed [OUT_BITS-1:0] sext_bias(input logic signed [DATA_BITS-1:0] b);
      return {{(OUT_BITS-DATA_BITS){b[DATA_BITS-1]}}, b};
   endfunction

   logic                        adv_s;
   logic                        acc_s;
   logic [CCW-1:0]              col_r;
   logic [RCW-1:0]              row_r;
   logic [RCW-1:0]              row_off_s;
   logic [CCW-1:0]              col_off_s;
   logic                        win_ok_s;
   logic [ORW-1:0]              row_sh_s;
   logic [OCW-1:0]              col_sh_s;
   logic signed [DATA_BITS-1:0] win_r [9];
   logic signed [DATA_BITS-1:0] lb0_r [WIDTH];
   logic signed [DATA_BITS-1:0] lb1_r [WIDTH];
   logic                        win_v_r;
   logic                        s1_v_r;
   logic                        out_valid_r;
   logic                        frame_done_r;
   logic [ORW-1:0]              win_row_r;
   logic [ORW-1:0]              s1_row_r;
   logic [ORW-1:0]              out_row_r;
   logic [OCW-1:0]              win_col_r;
   logic [OCW-1:0]              s1_col_r;
   logic [OCW-1:0]              out_col_r;
   logic signed [PW-1:0]        prod_r [NUM_OC][9];
   logic signed [OUT_BITS-1:0]  res_s [NUM_OC];
   logic [NUM_OC*OUT_BITS-1:0]  out_data_r;

   // handshake and window-position decode for the pixel being offered
   always_comb begin
      adv_s     = !out_valid_r || out_ready;
      acc_s     = in_valid && adv_s && !clr;
      row_off_s = row_r - RCW'(2);
      col_off_s = col_r - CCW'(2);
      win_ok_s  = (row_r >= RCW'(2)) && (col_r >= CCW'(2)) &&
                  ((STRIDE == 1) || (!row_off_s[0] && !col_off_s[0]));
      row_sh_s  = ORW'({{ORW{1'b0}}, row_off_s} >> SH);
      col_sh_s  = OCW'({{OCW{1'b0}}, col_off_s} >> SH);
   end

   assign in_ready   = adv_s && !clr;
   assign out_valid  = out_valid_r;
   assign out_data   = out_data_r;
   assign out_row    = out_row_r;
   assign out_col    = out_col_r;
   assign frame_done = frame_done_r;

   // pixel counters, 3x3 window, stage valids and pipelined output coordinates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_r <= {CCW{1'b0}};
         row_r <= {RCW{1'b0}};
         for (int k = 0; k < 9; k++) win_r[k] <= {DATA_BITS{1'b0}};
         win_v_r     <= 1'b0;
         s1_v_r      <= 1'b0;
         out_valid_r <= 1'b0;
         win_row_r   <= {ORW{1'b0}};
         s1_row_r    <= {ORW{1'b0}};
         out_row_r   <= {ORW{1'b0}};
         win_col_r   <= {OCW{1'b0}};
         s1_col_r    <= {OCW{1'b0}};
         out_col_r   <= {OCW{1'b0}};
      end else if (clr) begin
         col_r <= {CCW{1'b0}};
         row_r <= {RCW{1'b0}};
         for (int k = 0; k < 9; k++) win_r[k] <= {DATA_BITS{1'b0}};
         win_v_r     <= 1'b0;
         s1_v_r      <= 1'b0;
         out_valid_r <= 1'b0;
         win_row_r   <= {ORW{1'b0}};
         s1_row_r    <= {ORW{1'b0}};
         out_row_r   <= {ORW{1'b0}};
         win_col_r   <= {OCW{1'b0}};
         s1_col_r    <= {OCW{1'b0}};
         out_col_r   <= {OCW{1'b0}};
      end else if (adv_s) begin
         if (acc_s) begin
            if (col_r == COL_LAST) begin
               col_r <= {CCW{1'b0}};
               row_r <= (row_r == ROW_LAST) ? {RCW{1'b0}} : row_r + RCW'(1);
            end else begin
               col_r <= col_r + CCW'(1);
            end
            // window row 0 is the oldest image row, column 2 the newest pixel
            for (int r = 0; r < 3; r++) begin
               win_r[3*r]   <= win_r[3*r+1];
               win_r[3*r+1] <= win_r[3*r+2];
            end
            win_r[2]  <= lb1_r[col_r];
            win_r[5]  <= lb0_r[col_r];
            win_r[8]  <= in_data;
            win_row_r <= row_sh_s;
            win_col_r <= col_sh_s;
         end
         win_v_r     <= acc_s && win_ok_s;
         s1_v_r      <= win_v_r;
         s1_row_r    <= win_row_r;
         s1_col_r    <= win_col_r;
         out_valid_r <= s1_v_r;
         out_row_r   <= s1_row_r;
         out_col_r   <= s1_col_r;
      end
   end

   // two-row line buffer; contents need no reset
   always_ff @(posedge clk) begin
      if (acc_s) begin
         lb1_r[col_r] <= lb0_r[col_r];
         lb0_r[col_r] <= in_data;
      end
   end

   // per-channel adder tree over registered products plus bias, with optional ReLU
   always_comb begin
      for (int c = 0; c < NUM_OC; c++) begin
         logic signed [OUT_BITS-1:0] sum_v;
         sum_v = sext_bias(bias[c*DATA_BITS +: DATA_BITS]);
         for (int k = 0; k < 9; k++) begin
            sum_v = sum_v + sext_prod(prod_r[c][k]);
         end
         if ((RELU != 0) && sum_v[OUT_BITS-1]) begin
            res_s[c] = {OUT_BITS{1'b0}};
         end else begin
            res_s[c] = sum_v;
         end
      end
   end

   // product and result registers advance with the handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_OC; c++)
            for (int k = 0; k < 9; k++) prod_r[c][k] <= {PW{1'b0}};
         out_data_r <= {(NUM_OC*OUT_BITS){1'b0}};
      end else if (adv_s) begin
         for (int c = 0; c < NUM_OC; c++) begin
            for (int k = 0; k < 9; k++)
               prod_r[c][k] <= mul_ext(win_r[k], weights[(c*9+k)*DATA_BITS +: DATA_BITS]);
            out_data_r[c*OUT_BITS +: OUT_BITS] <= res_s[c];
         end
      end
   end

   // one-cycle pulse after the last result of a frame is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done_r <= 1'b0;
      end else if (clr) begin
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= out_valid_r && out_ready &&
                         (out_row_r == OROW_LAST) && (out_col_r == OCOL_LAST);
      end
   end

endmodule
